// File: rtl/quad_updown_decoder.sv
// Quadrature A/B decoder: synchronises and filters the encoder channels, tracks the
// gray-code phase and emits registered up_dwn step commands plus a position count.
module quad_updown_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [1:0]       up_dwn,
  output logic [WIDTH-1:0] count,
  output logic             err,
  output logic             primed
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FLT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [CW-1:0] FLT_FULL = CW'(FILTER_LEN);

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [1:0]             ab_s;
  logic [1:0]             ab_f;
  logic [CW-1:0]          fcnt [2];
  logic [1:0]             ab_hold;
  logic [CW-1:0]          pcnt;
  logic [CW-1:0]          pcnt_nxt;
  logic                   prime_now;
  logic [1:0]             phase;
  logic [1:0]             cmd;

  function automatic logic [1:0] fwd_phase(input logic [1:0] p);
    case (p)
      2'b00:   fwd_phase = 2'b01;
      2'b01:   fwd_phase = 2'b11;
      2'b11:   fwd_phase = 2'b10;
      default: fwd_phase = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] step_cmd(input logic [1:0] old_ph, input logic [1:0] new_ph);
    if (new_ph == old_ph)                 step_cmd = CMD_IDLE;
    else if (new_ph == fwd_phase(old_ph)) step_cmd = CMD_INC;
    else if (old_ph == fwd_phase(new_ph)) step_cmd = CMD_DEC;
    else                                  step_cmd = CMD_ILL;
  endfunction

  // Stage: synchronisers (bit 1 = channel A, bit 0 = channel B)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], enc_a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], enc_b};
    end
  end

  assign ab_s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // Stage: per-channel stability filter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ab_f <= '0;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ab_s[i] == ab_f[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_LAST) begin
          fcnt[i] <= '0;
          ab_f[i] <= ab_s[i];
        end else begin
          fcnt[i] <= fcnt[i] + CW'(1);
        end
      end
    end
  end

  // Priming tracks how long the joint synchronised phase has held still
  always_comb begin
    pcnt_nxt = pcnt;
    if (ab_s != ab_hold)      pcnt_nxt = CW'(1);
    else if (pcnt != FLT_FULL) pcnt_nxt = pcnt + CW'(1);
  end

  assign prime_now = !primed && (pcnt_nxt == FLT_FULL);
  assign cmd       = step_cmd(phase, ab_f);

  // Stage: phase tracking, command and position registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ab_hold <= '0;
      pcnt    <= '0;
      phase   <= '0;
      primed  <= 1'b0;
      up_dwn  <= CMD_IDLE;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      up_dwn <= CMD_IDLE;
      if (!primed) begin
        ab_hold <= ab_s;
        pcnt    <= pcnt_nxt;
        if (prime_now) begin
          phase  <= ab_s;
          primed <= 1'b1;
        end
      end else begin
        phase  <= ab_f;
        up_dwn <= cmd;
      end

      if (clr) begin
        count <= '0;
        err   <= 1'b0;
      end else if (primed) begin
        case (cmd)
          CMD_INC: count <= count + WIDTH'(1);
          CMD_DEC: count <= count - WIDTH'(1);
          CMD_ILL: err   <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
